// File: rtl/gamma_amplitude_monitor_pkg.sv
// ============================================================================
// Module : gamma_amplitude_monitor_pkg
// Brief  : Shared fixed-point constants, saturation helper and monitor FSM
//          state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gamma_amplitude_monitor_pkg;

    localparam int FXP_WIDTH = 18;
    localparam int FXP_FRAC  = 14;

    // Largest positive value of a signed w-bit word, 2^(w-1)-1.
    function automatic logic [63:0] fxp_sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } mon_state_e;

endpackage

`default_nettype wire

// File: rtl/alpha_max_beta_min_amp.sv
// ============================================================================
// Module : alpha_max_beta_min_amp
// Brief  : Combinational magnitude estimate max(|x|,|y|) + min(|x|,|y|)/2,
//          saturating at 2^(WIDTH-1)-1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alpha_max_beta_min_amp
    import gamma_amplitude_monitor_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH
) (
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    output logic        [WIDTH-1:0] amp_o
);

    localparam logic [WIDTH-1:0]        SAT_MAX  = WIDTH'(fxp_sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] w_neg_x;
    logic signed [WIDTH-1:0] w_neg_y;
    logic        [WIDTH-1:0] w_abs_x;
    logic        [WIDTH-1:0] w_abs_y;
    logic        [WIDTH-1:0] w_hi;
    logic        [WIDTH-1:0] w_lo;
    logic        [WIDTH:0]   w_sum;

    assign w_neg_x = -x_i;
    assign w_neg_y = -y_i;

    always_comb begin
        // The most negative code has no positive twin; clamp it.
        if (x_i == MOST_NEG)      w_abs_x = SAT_MAX;
        else if (x_i[WIDTH-1])    w_abs_x = $unsigned(w_neg_x);
        else                      w_abs_x = $unsigned(x_i);

        if (y_i == MOST_NEG)      w_abs_y = SAT_MAX;
        else if (y_i[WIDTH-1])    w_abs_y = $unsigned(w_neg_y);
        else                      w_abs_y = $unsigned(y_i);

        if (w_abs_x >= w_abs_y) begin
            w_hi = w_abs_x;
            w_lo = w_abs_y;
        end else begin
            w_hi = w_abs_y;
            w_lo = w_abs_x;
        end

        w_sum = {1'b0, w_hi} + {1'b0, (w_lo >> 1)};
        amp_o = (w_sum > {1'b0, SAT_MAX}) ? SAT_MAX : w_sum[WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/gamma_amplitude_monitor.sv
// ============================================================================
// Module : gamma_amplitude_monitor
// Brief  : Oscillation amplitude monitor: instantaneous amplitude, EMA
//          envelope, and windowed max / nonzero-min / rising zero crossings.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gamma_amplitude_monitor
    import gamma_amplitude_monitor_pkg::*;
#(
    parameter int WIDTH     = FXP_WIDTH,
    parameter int FRAC      = FXP_FRAC,
    parameter int ENV_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] sample_x,
    input  logic signed [WIDTH-1:0] sample_y,
    input  logic                    start,
    input  logic [15:0]             settle_len,
    input  logic [15:0]             window_len,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        amp_inst,
    output logic [WIDTH-1:0]        amp_env,
    output logic [WIDTH-1:0]        amp_max,
    output logic [WIDTH-1:0]        amp_min,
    output logic [15:0]             crossings
);

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(fxp_sat_max(WIDTH));

    if (FRAC >= WIDTH) begin : g_frac_check
        $error("FRAC must be smaller than WIDTH");
    end

    mon_state_e       state_q, state_d;
    logic [15:0]      settle_len_q, settle_len_d;
    logic [15:0]      window_len_q, window_len_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_max_q, acc_max_d;
    logic [WIDTH-1:0] acc_min_q, acc_min_d;
    logic [15:0]      acc_cross_q, acc_cross_d;
    logic [WIDTH-1:0] amp_max_q, amp_max_d;
    logic [WIDTH-1:0] amp_min_q, amp_min_d;
    logic [15:0]      crossings_q, crossings_d;
    logic [WIDTH-1:0] amp_inst_q;
    logic [WIDTH-1:0] amp_env_q;
    logic             prev_neg_q;

    logic [WIDTH-1:0]        w_amp;
    logic signed [WIDTH:0]   w_env_diff;
    logic signed [WIDTH:0]   w_env_sum;
    logic [WIDTH-1:0]        w_max_upd;
    logic [WIDTH-1:0]        w_min_upd;
    logic [15:0]             w_cross_upd;
    logic [15:0]             w_win_eff;
    logic [15:0]             w_cnt_inc;
    logic                    w_rise;

    alpha_max_beta_min_amp #(
        .WIDTH (WIDTH)
    ) u_amp (
        .x_i   (sample_x),
        .y_i   (sample_y),
        .amp_o (w_amp)
    );

    // Both operands are non-negative, so a zero MSB is their sign extension.
    assign w_env_diff = $signed({1'b0, w_amp}) - $signed({1'b0, amp_env_q});
    assign w_env_sum  = $signed({1'b0, amp_env_q}) + (w_env_diff >>> ENV_SHIFT);

    assign w_rise      = prev_neg_q & ~sample_x[WIDTH-1];
    assign w_max_upd   = (w_amp > acc_max_q) ? w_amp : acc_max_q;
    assign w_min_upd   = ((w_amp != '0) && (w_amp < acc_min_q)) ? w_amp : acc_min_q;
    assign w_cross_upd = (w_rise && (acc_cross_q != 16'hFFFF)) ? acc_cross_q + 16'd1
                                                                : acc_cross_q;
    assign w_win_eff   = (window_len_q == 16'd0) ? 16'd1 : window_len_q;
    assign w_cnt_inc   = cnt_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        settle_len_d = settle_len_q;
        window_len_d = window_len_q;
        cnt_d        = cnt_q;
        acc_max_d    = acc_max_q;
        acc_min_d    = acc_min_q;
        acc_cross_d  = acc_cross_q;
        amp_max_d    = amp_max_q;
        amp_min_d    = amp_min_q;
        crossings_d  = crossings_q;
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_REPORT);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    settle_len_d = settle_len;
                    window_len_d = window_len;
                    cnt_d        = 16'd0;
                    if (settle_len == 16'd0) begin
                        state_d     = ST_MEASURE;
                        acc_max_d   = '0;
                        acc_min_d   = SAT_MAX;
                        acc_cross_d = 16'd0;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (clk_en) begin
                    if (w_cnt_inc == settle_len_q) begin
                        state_d     = ST_MEASURE;
                        cnt_d       = 16'd0;
                        acc_max_d   = '0;
                        acc_min_d   = SAT_MAX;
                        acc_cross_d = 16'd0;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end
            ST_MEASURE: begin
                if (clk_en) begin
                    acc_max_d   = w_max_upd;
                    acc_min_d   = w_min_upd;
                    acc_cross_d = w_cross_upd;
                    if (w_cnt_inc == w_win_eff) begin
                        state_d     = ST_REPORT;
                        cnt_d       = 16'd0;
                        amp_max_d   = w_max_upd;
                        // A zero max means every amp was zero, so no min exists.
                        amp_min_d   = (w_max_upd == '0) ? '0 : w_min_upd;
                        crossings_d = w_cross_upd;
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_len_q <= 16'd0;
            window_len_q <= 16'd0;
            cnt_q        <= 16'd0;
            acc_max_q    <= '0;
            acc_min_q    <= '0;
            acc_cross_q  <= 16'd0;
            amp_max_q    <= '0;
            amp_min_q    <= '0;
            crossings_q  <= 16'd0;
            amp_inst_q   <= '0;
            amp_env_q    <= '0;
            prev_neg_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_len_q <= settle_len_d;
            window_len_q <= window_len_d;
            cnt_q        <= cnt_d;
            acc_max_q    <= acc_max_d;
            acc_min_q    <= acc_min_d;
            acc_cross_q  <= acc_cross_d;
            amp_max_q    <= amp_max_d;
            amp_min_q    <= amp_min_d;
            crossings_q  <= crossings_d;
            if (clk_en) begin
                amp_inst_q <= w_amp;
                amp_env_q  <= w_env_sum[WIDTH-1:0];
                prev_neg_q <= sample_x[WIDTH-1];
            end
        end
    end

    assign amp_inst  = amp_inst_q;
    assign amp_env   = amp_env_q;
    assign amp_max   = amp_max_q;
    assign amp_min   = amp_min_q;
    assign crossings = crossings_q;

endmodule

`default_nettype wire

// File: tb/tb_gamma_amplitude_monitor.sv
// ============================================================================
// Module : tb_gamma_amplitude_monitor
// Brief  : Directed, table-driven self-checking bench for the amplitude monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gamma_amplitude_monitor;

    logic               clk;
    logic               rst;
    logic               clk_en;
    logic signed [17:0] sample_x;
    logic signed [17:0] sample_y;
    logic               start;
    logic [15:0]        settle_len;
    logic [15:0]        window_len;
    logic               busy;
    logic               done;
    logic [17:0]        amp_inst;
    logic [17:0]        amp_env;
    logic [17:0]        amp_max;
    logic [17:0]        amp_min;
    logic [15:0]        crossings;

    int n_checks = 0;
    int n_errors = 0;
    int done_pulses = 0;

    typedef struct {
        logic signed [17:0] x;
        logic signed [17:0] y;
        logic [17:0]        amp;
    } vec_t;

    vec_t vecs[10];
    logic signed [17:0] sine_tab[16];

    gamma_amplitude_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .sample_x   (sample_x),
        .sample_y   (sample_y),
        .start      (start),
        .settle_len (settle_len),
        .window_len (window_len),
        .busy       (busy),
        .done       (done),
        .amp_inst   (amp_inst),
        .amp_env    (amp_env),
        .amp_max    (amp_max),
        .amp_min    (amp_min),
        .crossings  (crossings)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic signed [17:0] xv, input logic signed [17:0] yv);
        sample_x = xv;
        sample_y = yv;
        clk_en   = 1'b1;
        tick();
        clk_en   = 1'b0;
    endtask

    initial begin
        int base;

        vecs[0] = '{x:  18'sd16384,   y:  18'sd8192,    amp: 18'd20480};
        vecs[1] = '{x: -18'sd131072,  y:  18'sd0,       amp: 18'd131071};
        vecs[2] = '{x:  18'sd0,       y:  18'sd0,       amp: 18'd0};
        vecs[3] = '{x: -18'sd5,       y:  18'sd3,       amp: 18'd6};
        vecs[4] = '{x:  18'sd3,       y: -18'sd5,       amp: 18'd6};
        vecs[5] = '{x:  18'sd131071,  y:  18'sd131071,  amp: 18'd131071};
        vecs[6] = '{x: -18'sd100,     y: -18'sd100,     amp: 18'd150};
        vecs[7] = '{x:  18'sd7,       y:  18'sd1,       amp: 18'd7};
        vecs[8] = '{x: -18'sd131072,  y: -18'sd131072,  amp: 18'd131071};
        vecs[9] = '{x:  18'sd1000,    y: -18'sd3000,    amp: 18'd3500};

        sine_tab = '{18'sd0, 18'sd6270, 18'sd11585, 18'sd15137,
                     18'sd16384, 18'sd15137, 18'sd11585, 18'sd6270,
                     18'sd0, -18'sd6270, -18'sd11585, -18'sd15137,
                     -18'sd16384, -18'sd15137, -18'sd11585, -18'sd6270};

        rst = 1'b1; clk_en = 1'b0; start = 1'b0;
        sample_x = '0; sample_y = '0; settle_len = '0; window_len = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_amp_inst", amp_inst, 0);
        check("reset_amp_env", amp_env, 0);
        check("reset_amp_max", amp_max, 0);
        check("reset_crossings", crossings, 0);

        // Envelope from zero with a constant amplitude of 16384.
        strobe(18'sd16384, 18'sd0);
        check("env_first_strobe", amp_env, 1024);
        check("env_amp_inst", amp_inst, 16384);
        for (int i = 0; i < 199; i++) strobe(18'sd16384, 18'sd0);
        check("env_converged", (amp_env >= 18'd16368) && (amp_env <= 18'd16400), 1);

        // Amplitude approximation table.
        for (int i = 0; i < 10; i++) begin
            strobe(vecs[i].x, vecs[i].y);
            check($sformatf("amp_vec%0d", i), amp_inst, vecs[i].amp);
        end
        sample_x = 18'sd123;
        tick();
        check("amp_inst_hold", amp_inst, vecs[9].amp);

        // Settle 5 / window 8 ramp, with gaps and a start while busy.
        settle_len = 16'd5; window_len = 16'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("ramp_busy_after_start", busy, 1);
        base = done_pulses;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; settle_len = 16'd0; window_len = 16'd1;
            end
            strobe(-18'sd1, 18'sd0);
            start = 1'b0;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            strobe(18'(i - 4), 18'sd0);
            if (i < 7) tick();
        end
        check("ramp_no_early_done", done_pulses - base, 0);
        check("ramp_done", done, 1);
        check("ramp_busy_in_report", busy, 1);
        check("ramp_amp_max", amp_max, 4);
        check("ramp_amp_min", amp_min, 1);
        check("ramp_crossings", crossings, 1);
        start = 1'b1; settle_len = 16'd0; window_len = 16'd1;
        tick();
        start = 1'b0;
        check("ramp_done_one_cycle", done, 0);
        check("start_in_report_ignored", busy, 0);
        check("ramp_single_pulse", done_pulses - base, 1);

        // window_len = 0 measures exactly one strobe.
        settle_len = 16'd0; window_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        strobe(18'sd5, 18'sd0);
        check("win0_done", done, 1);
        check("win0_amp_max", amp_max, 5);
        check("win0_amp_min", amp_min, 5);
        check("win0_crossings", crossings, 0);
        tick();

        // A window of only zero amplitude reports min 0.
        window_len = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        strobe(18'sd0, 18'sd0);
        check("zero_done", done, 1);
        check("zero_amp_min", amp_min, 0);
        check("zero_amp_max", amp_max, 0);
        tick();

        // Sinusoid, period 16, window 64, pre-window sample negative.
        for (int n = 0; n < 16; n++) strobe(sine_tab[n], 18'sd0);
        settle_len = 16'd0; window_len = 16'd64; start = 1'b1;
        tick();
        start = 1'b0;
        base = done_pulses;
        for (int n = 0; n < 64; n++) strobe(sine_tab[n % 16], 18'sd0);
        check("sine_no_early_done", done_pulses - base, 0);
        check("sine_done", done, 1);
        check("sine_crossings", crossings, 4);
        check("sine_amp_max", amp_max, 16384);
        check("sine_amp_min", amp_min, 6270);
        tick();
        strobe(-18'sd9000, 18'sd0);
        strobe(18'sd100, 18'sd0);
        check("hold_amp_max", amp_max, 16384);
        check("hold_crossings", crossings, 4);

        // Reset mid-measurement, with start asserted in the reset cycle.
        settle_len = 16'd0; window_len = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        strobe(18'sd300, 18'sd0);
        strobe(-18'sd200, 18'sd0);
        strobe(18'sd50, 18'sd0);
        rst = 1'b1; clk_en = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; clk_en = 1'b0; start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_amp_max", amp_max, 0);
        check("rst_amp_min", amp_min, 0);
        check("rst_crossings", crossings, 0);
        check("rst_amp_inst", amp_inst, 0);
        check("rst_amp_env", amp_env, 0);
        base = done_pulses;
        for (int i = 0; i < 20; i++) strobe(18'sd400, 18'sd0);
        check("rst_no_done_after", done_pulses - base, 0);
        check("rst_stays_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gamma_amplitude_monitor.md
GAMMA_AMPLITUDE_MONITOR -- requirements
Module: gamma_amplitude_monitor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 18, meaning sample width in signed fixed-point.
REQ-002 The module SHALL have parameter FRAC, default 14, meaning fractional bits (Q4.14).
REQ-003 The module SHALL have parameter ENV_SHIFT, default 4, meaning envelope EMA coefficient 2^-ENV_SHIFT.
REQ-004 The module SHALL have these ports, one per line:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- clk_en, in, 1: sample strobe (oscillator update rate).
- sample_x, in, WIDTH signed: L2/3 x output of cortical_column.
- sample_y, in, WIDTH signed: L2/3 y output of cortical_column.
- start, in, 1: one-cycle request to begin a measurement.
- settle_len, in, 16: clk_en samples discarded before measuring.
- window_len, in, 16: clk_en samples measured.
- busy, out, 1: measurement in progress.
- done, out, 1: one-cycle pulse when results are valid.
- amp_inst, out, WIDTH unsigned-valued: instantaneous amplitude.
- amp_env, out, WIDTH: EMA envelope of amp_inst.
- amp_max, out, WIDTH: window maximum.
- amp_min, out, WIDTH: window nonzero minimum.
- crossings, out, 16: rising zero crossings of sample_x in the window.

Function
REQ-005 The block SHALL compute |x|, |y| with -2^(WIDTH-1) saturating to 2^(WIDTH-1)-1.
REQ-006 The block SHALL compute amp = max(|x|,|y|) + (min(|x|,|y|)>>1), saturating at 2^(WIDTH-1)-1.
REQ-007 The block SHALL register amp_inst on each clk_en cycle, one clk after the sampled inputs; it SHALL hold between strobes.
REQ-008 amp_env SHALL update on every clk_en, independent of FSM state, as env + ((amp - env) >>> ENV_SHIFT), using sign-extended intermediates of width WIDTH+1.
REQ-009 The FSM SHALL have states IDLE, SETTLE, MEASURE and REPORT.
REQ-010 In IDLE, start=1 SHALL latch settle_len and window_len, and SHALL enter SETTLE, or MEASURE if settle_len=0; busy SHALL be high in every state except IDLE.
REQ-011 SETTLE SHALL count clk_en strobes and move to MEASURE on the cycle the settle_len-th strobe is consumed.
REQ-012 On MEASURE entry, the accumulators SHALL initialise to max=0, min=2^(WIDTH-1)-1 and crossings=0.
REQ-013 window_len=0 SHALL be treated as 1.
REQ-014 In MEASURE, each clk_en SHALL update max, and SHALL update min only for amp>0.
REQ-015 A crossing SHALL be counted when the previous sample_x<0 and the current sample_x>=0; the first sample of the window SHALL be compared against the last pre-window sample.
REQ-016 crossings SHALL saturate at 65535.
REQ-017 After the window_len-th strobe, the FSM SHALL enter REPORT and copy the accumulators to the outputs.
REQ-018 If no nonzero amp was seen, amp_min SHALL report 0.
REQ-019 REPORT SHALL assert done for exactly one clk and then return to IDLE.
REQ-020 amp_max, amp_min and crossings SHALL hold until the next REPORT.
REQ-021 start while busy SHALL be ignored.
REQ-022 start in the same cycle as REPORT SHALL be ignored.
REQ-023 clk_en low SHALL freeze all counters and accumulators.

Reset
REQ-024 rst SHALL return the FSM to IDLE, including mid-measurement, with no done pulse.
REQ-025 rst SHALL clear busy, done, amp_inst, amp_env, amp_max, amp_min, crossings, all counters and the previous-sign register to 0.
REQ-026 rst SHALL dominate start in the same cycle.

Structure
REQ-027 WIDTH/FRAC defaults, the saturation constant 2^(WIDTH-1)-1 and the FSM state encoding SHALL live in the shared fixed-point package used by cortical_column.
REQ-028 The amplitude approximation (REQ-005/006) SHALL be one combinational sub-module, alpha_max_beta_min_amp, reusable by other monitors.

Verification
REQ-029 x=16384, y=8192 with strobes -> amp_inst=20480 one clk after the strobe; x=-131072, y=0 -> 131071.
REQ-030 Constant amp 16384 from env=0 with ENV_SHIFT=4 -> env=1024 after the first strobe and within 16 LSB of 16384 after 200 strobes.
REQ-031 settle_len=5, window_len=8, x ramping -4..+3 per strobe with y=0 -> done on the clk after the 13th strobe; amp_max=4, amp_min=1 (zero excluded), crossings=1; busy high from start+1 to done.
REQ-032 Sinusoid x with period 16 strobes, window_len=64, settle_len=0 -> crossings=4.
REQ-033 window_len=0 -> done after exactly 1 measured strobe.
REQ-034 rst asserted mid-MEASURE -> busy=0 next clk, no done pulse, outputs 0; start during busy has no effect on the done timing.
